// File: rtl/bist_pkg.sv
// Shared constants and command encodings for the BIST memory responder.
// Imported by the address counter, the responder top and the bench.
package bist_pkg;

   localparam int DEFAULT_ADDR_W = 4;

   function automatic int depthOf(input int addrW);
      return 1 << addrW;
   endfunction

   // Command shorthand; the responder itself decodes the raw read/write strobes.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2
   } cmd_e;

endpackage

// File: rtl/bist_addr_counter.sv
// Up/down march address counter with clear > preset > enable priority.
// Carry flags the terminal count in the current counting direction.
module bist_addr_counter
   import bist_pkg::*;
#(
   parameter int ADDR_W = DEFAULT_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              up_down,
   input  logic              reset,
   input  logic              preset,
   output logic [ADDR_W-1:0] addr,
   output logic              carry
);

   localparam logic [ADDR_W-1:0] addrOne = ADDR_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr <= '0;
      end else if (reset) begin
         addr <= '0;
      end else if (preset) begin
         addr <= '1;
      end else if (en) begin
         addr <= up_down ? addr + addrOne : addr - addrOne;
      end
   end

   assign carry = en & ((up_down & (&addr)) | (~up_down & ~(|addr)));

endmodule

// File: rtl/bist_mem_responder.sv
// Memory-side BIST responder: address counter, 1-bit array under test,
// registered read comparator and a stuck-at fault injector on the read path.
module bist_mem_responder
   import bist_pkg::*;
#(
   parameter int ADDR_W = DEFAULT_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              up_down,
   input  logic              reset,
   input  logic              preset,
   input  logic              read,
   input  logic              write,
   input  logic              data,
   input  logic              fault_en,
   input  logic [ADDR_W-1:0] fault_addr,
   input  logic              fault_val,
   output logic [ADDR_W-1:0] addr,
   output logic              rd_data,
   output logic              carry,
   output logic              is_equal
);

   localparam int DEPTH = depthOf(ADDR_W);

   logic mem [DEPTH];
   logic wrQual;
   logic rdQual;
   logic cellVal;

   bist_addr_counter #(
      .ADDR_W (ADDR_W)
   ) addrCounter (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .up_down (up_down),
      .reset   (reset),
      .preset  (preset),
      .addr    (addr),
      .carry   (carry)
   );

   // A simultaneous write wins over the read, so the read is simply dropped.
   assign wrQual  = en & write & ~reset & ~preset;
   assign rdQual  = en & read & ~write & ~reset & ~preset;
   assign cellVal = (fault_en && (fault_addr == addr)) ? fault_val : mem[addr];

   // The array shares the reset branch so an edge under rst never lands a write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data  <= 1'b0;
         is_equal <= 1'b1;
      end else begin
         if (wrQual) begin
            mem[addr] <= data;
         end
         if (rdQual) begin
            rd_data  <= cellVal;
            is_equal <= (cellVal == data);
         end else begin
            is_equal <= 1'b1;
         end
      end
   end

endmodule
